// File: rtl/ovc_credit_status_if.sv
// ovc_credit_status_if
//   Bundles the signals between the output-port OVC credit tracker and its
//   neighbours: allocator grants, crossbar departures and returned credits
//   go in, and the registered OVC status vectors come out.
//   master : allocator / crossbar / credit-return side (drives the events)
//   slave  : ovc_credit_status (drives the status vectors)
//   Signals:
//     ovc_allocated_in [V]    OVC granted to a header this cycle
//     flit_sent_in            a flit leaves the output port this cycle
//     flit_sent_vc     [V]    one-hot OVC of the departing flit
//     flit_sent_tail          departing flit is a tail
//     credit_in        [V]    one returned credit per set bit
//     ovc_free         [V]    OVC may be granted
//     ovc_not_full     [V]    OVC credit count is non-zero
//     ovc_credit_cnt   [V*CW] packed credit counters, VC0 in the LSBs
//     credit_error     [V]    sticky protocol-violation flags
interface ovc_credit_status_if #(
  parameter int V = 4,
  parameter int B = 4
);
  localparam int CW = $clog2(B + 1);

  logic [V-1:0]    ovc_allocated_in;
  logic            flit_sent_in;
  logic [V-1:0]    flit_sent_vc;
  logic            flit_sent_tail;
  logic [V-1:0]    credit_in;
  logic [V-1:0]    ovc_free;
  logic [V-1:0]    ovc_not_full;
  logic [V*CW-1:0] ovc_credit_cnt;
  logic [V-1:0]    credit_error;

  modport master (
    output ovc_allocated_in, flit_sent_in, flit_sent_vc, flit_sent_tail, credit_in,
    input  ovc_free, ovc_not_full, ovc_credit_cnt, credit_error
  );

  modport slave (
    input  ovc_allocated_in, flit_sent_in, flit_sent_vc, flit_sent_tail, credit_in,
    output ovc_free, ovc_not_full, ovc_credit_cnt, credit_error
  );
endinterface

// File: rtl/ovc_credit_status.sv
// ovc_credit_status
//   Per-output-port tracker of downstream OVC ownership and credits. It
//   consumes the allocator's OVC grants, the crossbar's flit departures and
//   the downstream router's credit returns, and produces the registered
//   "OVC free" / "OVC not full" masks used by the allocator next cycle.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    ovc_credit_status_if.slave (events in, status vectors out)
//   Parameters:
//     V          virtual channels per port
//     B          downstream buffer depth per VC in flits (>= 2)
//     ATOMIC_VC  1: an OVC is reusable only once its tail has left and all
//                B credits are back; 0: reusable as soon as the tail leaves
module ovc_credit_status #(
  parameter int V         = 4,
  parameter int B         = 4,
  parameter int ATOMIC_VC = 0
) (
  input logic               clk,
  input logic               reset,
  ovc_credit_status_if.slave bus
);
  localparam int CW = $clog2(B + 1);
  localparam logic [CW-1:0] B_CNT = CW'(B);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    ALLOC = 2'd1,
    DRAIN = 2'd2
  } vc_state_t;

  // Saturating credit update: returns {error, next count}. Send and credit
  // together cancel; an empty send or a credit into a full counter holds
  // the count and flags an error.
  function automatic logic [CW:0] cnt_update(input logic [CW-1:0] cnt,
                                             input logic dec, input logic inc);
    logic [CW-1:0] nxt;
    logic          err;
    nxt = cnt;
    err = 1'b0;
    if (dec && !inc) begin
      if (cnt == '0) err = 1'b1;
      else           nxt = cnt - 1'b1;
    end else if (inc && !dec) begin
      if (cnt == B_CNT) err = 1'b1;
      else              nxt = cnt + 1'b1;
    end
    return {err, nxt};
  endfunction

  vc_state_t     state_p1 [V];
  vc_state_t     state_nxt[V];
  logic [CW-1:0] cnt_p1   [V];
  logic [CW-1:0] cnt_nxt  [V];
  logic [V-1:0]  free_p1;
  logic [V-1:0]  not_full_p1;
  logic [V-1:0]  err_p1;
  logic [V-1:0]  cnt_err;
  logic [V-1:0]  fsm_err;
  logic [V-1:0]  dec;
  logic [V-1:0]  tail;

  assign dec  = {V{bus.flit_sent_in}} & bus.flit_sent_vc;
  assign tail = dec & {V{bus.flit_sent_tail}};

  // Stage 0: next credit count and next VC state from this cycle's events
  always_comb begin
    for (int v = 0; v < V; v++) begin
      {cnt_err[v], cnt_nxt[v]} = cnt_update(cnt_p1[v], dec[v], bus.credit_in[v]);
      state_nxt[v] = state_p1[v];
      fsm_err[v]   = 1'b0;
      unique case (state_p1[v])
        FREE: begin
          if (bus.ovc_allocated_in[v]) begin
            // A tail departing with its own grant is a single-flit packet.
            if (tail[v]) state_nxt[v] = (ATOMIC_VC != 0) ? DRAIN : FREE;
            else         state_nxt[v] = ALLOC;
          end else if (dec[v]) begin
            fsm_err[v] = 1'b1;
          end
        end
        ALLOC: begin
          // A second grant is ignored; the owning packet's tail still counts.
          fsm_err[v] = bus.ovc_allocated_in[v];
          if (tail[v]) state_nxt[v] = (ATOMIC_VC != 0) ? DRAIN : FREE;
        end
        DRAIN: begin
          fsm_err[v] = bus.ovc_allocated_in[v];
        end
        default: begin
          state_nxt[v] = FREE;
        end
      endcase
      // All credits back (possibly in the same update that entered DRAIN).
      if (state_nxt[v] == DRAIN && cnt_nxt[v] == B_CNT) state_nxt[v] = FREE;
    end
  end

  // Stage 1: registered state, counters and status masks
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < V; v++) begin
        state_p1[v] <= FREE;
        cnt_p1[v]   <= B_CNT;
      end
      free_p1     <= '1;
      not_full_p1 <= '1;
      err_p1      <= '0;
    end else begin
      for (int v = 0; v < V; v++) begin
        state_p1[v]    <= state_nxt[v];
        cnt_p1[v]      <= cnt_nxt[v];
        free_p1[v]     <= (state_nxt[v] == FREE);
        not_full_p1[v] <= (cnt_nxt[v] != '0);
      end
      err_p1 <= err_p1 | cnt_err | fsm_err;
    end
  end

  assign bus.ovc_free     = free_p1;
  assign bus.ovc_not_full = not_full_p1;
  assign bus.credit_error = err_p1;

  for (genvar g = 0; g < V; g++) begin : g_cnt_pack
    assign bus.ovc_credit_cnt[g*CW +: CW] = cnt_p1[g];
  end
endmodule

// File: tb/tb_ovc_credit_status.sv
module tb_ovc_credit_status;
  localparam int V  = 4;
  localparam int B  = 4;
  localparam int CW = 3;
  localparam int S_FREE  = 0;
  localparam int S_ALLOC = 1;
  localparam int S_DRAIN = 2;

  logic         clk = 1'b0;
  logic         rs  = 1'b1;
  logic [V-1:0] ga  = '0;
  logic         fs  = 1'b0;
  logic [V-1:0] fvc = '0;
  logic         ft  = 1'b0;
  logic [V-1:0] cr  = '0;

  int n_checks = 0;
  int n_err    = 0;

  // Reference: index 0 models ATOMIC_VC=0, index 1 models ATOMIC_VC=1.
  int       m_cnt[2][V];
  int       m_st [2][V];
  bit [V-1:0] m_err[2];

  ovc_credit_status_if #(.V(V), .B(B)) bus0 ();
  ovc_credit_status_if #(.V(V), .B(B)) bus1 ();

  assign bus0.ovc_allocated_in = ga;
  assign bus0.flit_sent_in     = fs;
  assign bus0.flit_sent_vc     = fvc;
  assign bus0.flit_sent_tail   = ft;
  assign bus0.credit_in        = cr;
  assign bus1.ovc_allocated_in = ga;
  assign bus1.flit_sent_in     = fs;
  assign bus1.flit_sent_vc     = fvc;
  assign bus1.flit_sent_tail   = ft;
  assign bus1.credit_in        = cr;

  ovc_credit_status #(.V(V), .B(B), .ATOMIC_VC(0)) dut0 (.clk(clk), .reset(rs), .bus(bus0));
  ovc_credit_status #(.V(V), .B(B), .ATOMIC_VC(1)) dut1 (.clk(clk), .reset(rs), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: one transaction-level update per clock from the rules of the block.
  task automatic model_update();
    for (int a = 0; a < 2; a++) begin
      if (rs) begin
        for (int v = 0; v < V; v++) begin
          m_cnt[a][v] = B;
          m_st[a][v]  = S_FREE;
        end
        m_err[a] = '0;
      end else begin
        for (int v = 0; v < V; v++) begin
          bit sent, back, is_tail;
          sent    = fs && fvc[v];
          back    = cr[v];
          is_tail = sent && ft;
          if (sent && !back) begin
            if (m_cnt[a][v] == 0) m_err[a][v] = 1'b1;
            else m_cnt[a][v] = m_cnt[a][v] - 1;
          end else if (back && !sent) begin
            if (m_cnt[a][v] == B) m_err[a][v] = 1'b1;
            else m_cnt[a][v] = m_cnt[a][v] + 1;
          end
          if (m_st[a][v] == S_FREE) begin
            if (ga[v]) m_st[a][v] = is_tail ? (a == 1 ? S_DRAIN : S_FREE) : S_ALLOC;
            else if (sent) m_err[a][v] = 1'b1;
          end else begin
            if (ga[v]) m_err[a][v] = 1'b1;
            if (m_st[a][v] == S_ALLOC && is_tail) m_st[a][v] = (a == 1) ? S_DRAIN : S_FREE;
          end
          if (m_st[a][v] == S_DRAIN && m_cnt[a][v] == B) m_st[a][v] = S_FREE;
        end
      end
    end
  endtask

  function automatic logic [V*CW-1:0] m_pack(input int a);
    logic [V*CW-1:0] r;
    for (int v = 0; v < V; v++) r[v*CW +: CW] = CW'(m_cnt[a][v]);
    return r;
  endfunction

  function automatic logic [V-1:0] m_free(input int a);
    logic [V-1:0] r;
    for (int v = 0; v < V; v++) r[v] = (m_st[a][v] == S_FREE);
    return r;
  endfunction

  function automatic logic [V-1:0] m_nf(input int a);
    logic [V-1:0] r;
    for (int v = 0; v < V; v++) r[v] = (m_cnt[a][v] != 0);
    return r;
  endfunction

  task automatic compare_all();
    chk("d0_free",     bus0.ovc_free,       m_free(0));
    chk("d0_not_full", bus0.ovc_not_full,   m_nf(0));
    chk("d0_cnt",      bus0.ovc_credit_cnt, m_pack(0));
    chk("d0_err",      bus0.credit_error,   m_err[0]);
    chk("d1_free",     bus1.ovc_free,       m_free(1));
    chk("d1_not_full", bus1.ovc_not_full,   m_nf(1));
    chk("d1_cnt",      bus1.ovc_credit_cnt, m_pack(1));
    chk("d1_err",      bus1.credit_error,   m_err[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic [V-1:0] g, input logic s,
                       input logic [V-1:0] vc, input logic t, input logic [V-1:0] c);
    rs = r; ga = g; fs = s; fvc = vc; ft = t; cr = c;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    // Reset then idle
    drive(1'b1, '0, 1'b0, '0, 1'b0, '0);
    idle(5);
    chk("rst_free",     bus0.ovc_free,       4'b1111);
    chk("rst_not_full", bus0.ovc_not_full,   4'b1111);
    chk("rst_cnt",      bus0.ovc_credit_cnt, 12'b100_100_100_100);
    chk("rst_err",      bus0.credit_error,   4'b0000);

    // Four-flit packet on VC1, no credits, then all credits back
    drive(1'b0, 4'b0010, 1'b0, '0, 1'b0, '0);
    chk("grant_free1", bus0.ovc_free[1], 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 4'b0010, (i == 3), '0);
      chk("pkt_cnt1", bus0.ovc_credit_cnt[1*CW +: CW], 3'(3 - i));
      if (i < 3) chk("pkt_free1_busy", bus0.ovc_free[1], 1'b0);
    end
    chk("pkt_not_full1", bus0.ovc_not_full[1], 1'b0);
    chk("pkt_free1_tail", bus0.ovc_free[1], 1'b1);
    chk("pkt_d1_drain", bus1.ovc_free[1], 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 4'b0010);
    chk("ret_cnt1", bus0.ovc_credit_cnt[1*CW +: CW], 3'd4);
    chk("ret_err1", bus0.credit_error[1], 1'b0);
    chk("ret_d1_free1", bus1.ovc_free[1], 1'b1);

    // Single-flit packet on VC2
    drive(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, '0);
    chk("sf_d1_free2", bus1.ovc_free[2], 1'b0);
    chk("sf_d1_cnt2",  bus1.ovc_credit_cnt[2*CW +: CW], 3'd3);
    chk("sf_d0_free2", bus0.ovc_free[2], 1'b1);
    idle(1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 4'b0100);
    chk("sf_d1_cnt2_back", bus1.ovc_credit_cnt[2*CW +: CW], 3'd4);
    chk("sf_d1_free2_back", bus1.ovc_free[2], 1'b1);

    // Send and credit together on VC0 at cnt=2
    drive(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 4'b0001, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 4'b0001, 1'b0, 4'b0001);
    chk("both_cnt0", bus0.ovc_credit_cnt[0 +: CW], 3'd2);
    chk("both_nf0",  bus0.ovc_not_full[0], 1'b1);

    // Credit overflow on VC3 is sticky
    drive(1'b0, '0, 1'b0, '0, 1'b0, 4'b1000);
    chk("ovf_cnt3", bus0.ovc_credit_cnt[3*CW +: CW], 3'd4);
    chk("ovf_err3", bus0.credit_error[3], 1'b1);
    idle(3);
    chk("ovf_err3_sticky", bus0.credit_error[3], 1'b1);

    // Double grant on VC0
    drive(1'b1, '0, 1'b0, '0, 1'b0, '0);
    chk("rst_err_clear", bus0.credit_error, 4'b0000);
    drive(1'b0, 4'b0001, 1'b0, '0, 1'b0, '0);
    drive(1'b0, 4'b0001, 1'b0, '0, 1'b0, '0);
    chk("dbl_err0",  bus0.credit_error[0], 1'b1);
    chk("dbl_free0", bus0.ovc_free[0], 1'b0);

    // Reset mid-packet at cnt=1
    drive(1'b1, '0, 1'b0, '0, 1'b0, '0);
    drive(1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 4'b0010, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 4'b0010, 1'b0, '0);
    chk("mid_cnt1", bus0.ovc_credit_cnt[1*CW +: CW], 3'd1);
    drive(1'b1, '0, 1'b0, '0, 1'b0, '0);
    chk("mid_rst_cnt",  bus0.ovc_credit_cnt, 12'b100_100_100_100);
    chk("mid_rst_free", bus0.ovc_free, 4'b1111);
    chk("mid_rst_err",  bus0.credit_error, 4'b0000);

    // Randomized traffic, mostly protocol-legal with occasional violations
    for (int i = 0; i < 3000; i++) begin
      logic [V-1:0] g, c, vc;
      logic         r, s, t;
      int           pv;
      r  = (i % 250 == 0) || ($urandom_range(0, 199) == 0);
      pv = $urandom_range(0, V - 1);
      g  = '0;
      if ($urandom_range(0, 3) == 0 && (m_st[0][pv] == S_FREE || $urandom_range(0, 19) == 0))
        g[pv] = 1'b1;
      pv = $urandom_range(0, V - 1);
      vc = '0;
      vc[pv] = 1'b1;
      s  = ($urandom_range(0, 1) == 1) && (m_cnt[0][pv] > 0 || $urandom_range(0, 29) == 0);
      t  = ($urandom_range(0, 2) == 0);
      for (int v = 0; v < V; v++)
        c[v] = ($urandom_range(0, 2) == 0) && (m_cnt[0][v] < B || $urandom_range(0, 29) == 0);
      drive(r, g, s, vc, t, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
